// File: rtl/spi_pkg.sv
// Shared definitions for the three-select SPI master: the state encoding and the
// elaboration-time sizing helpers.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // Rounded up so the generated SCLK never exceeds the requested frequency.
  function automatic int unsigned calc_half(input longint unsigned f_ck,
                                            input longint unsigned f_sclk);
    longint unsigned two_f;
    two_f = 2 * f_sclk;
    return 32'((f_ck + two_f - 1) / two_f);
  endfunction

  function automatic int unsigned hp_cnt_w(input int unsigned dat_w);
    return $clog2(2 * dat_w);
  endfunction

  function automatic logic [2:0] xss_mask(input logic [1:0] sel);
    logic [2:0] mask;
    mask = 3'b111;
    case (sel)
      2'd0:    mask = 3'b110;
      2'd1:    mask = 3'b101;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period divider: one-cycle TICK_o every C_H clocks, restartable by CLR_i so
// the first half-period of a transfer is always a full C_H cycles long.
module spi_half_tick #(
  parameter int unsigned C_H = 68
) (
  input  logic CK_i,
  input  logic RST_i,
  input  logic CLR_i,
  output logic TICK_o
);

  localparam int unsigned C_CNT_W = (C_H > 1) ? $clog2(C_H) : 1;
  localparam logic [C_CNT_W-1:0] C_TC = C_CNT_W'(C_H - 1);

  logic [C_CNT_W-1:0] cnt_q;
  logic [C_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (CLR_i || (cnt_q == C_TC)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign TICK_o = (cnt_q == C_TC);

endmodule

// File: rtl/spi_mst3cs.sv
// Single-byte SPI master (mode 0, MSB first) for the three-slave CN2 header.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for REQ_i; all selects high, SCLK low
//   ST_SETUP | one half-period with select low and MSB on COPI
//   ST_XFER  | 2*C_DAT_W half-periods; sample at end of high, shift at fall
//   ST_HOLD  | one half-period, SCLK low, select still low
//   ST_GAP   | one half-period, selects high; DONE_o issued at its end
module spi_mst3cs
  import spi_pkg::*;
#(
  parameter int unsigned C_F_CK   = 135_000_000,
  parameter int unsigned C_F_SCLK = 1_000_000,
  parameter int unsigned C_DAT_W  = 8
) (
  input  logic               CK_i,
  input  logic               RST_i,
  input  logic               REQ_i,
  input  logic [1:0]         CS_SELs_i,
  input  logic [C_DAT_W-1:0] WDATs_i,
  output logic               BUSY_o,
  output logic               DONE_o,
  output logic [C_DAT_W-1:0] RDATs_o,
  output logic               SCLK_o,
  output logic               COPI_o,
  output logic               XSS_0_o,
  output logic               XSS_1_o,
  output logic               XSS_2_o,
  input  logic               CIPO_0_i,
  input  logic               CIPO_1_i,
  input  logic               CIPO_2_i
);

  localparam int unsigned C_H    = calc_half(C_F_CK, C_F_SCLK);
  localparam int unsigned C_HP_W = hp_cnt_w(C_DAT_W);
  localparam logic [C_HP_W-1:0] C_HP_LAST = C_HP_W'(2 * C_DAT_W - 1);

  if (C_H < 4) begin : g_h_check
    $error("spi_mst3cs: half period of %0d clocks is below the minimum of 4", C_H);
  end

  spi_state_e         state_q, state_d;
  logic [C_HP_W-1:0]  hp_q, hp_d;
  logic [C_DAT_W-1:0] tx_q, tx_d;
  logic [C_DAT_W-1:0] rx_q, rx_d;
  logic [C_DAT_W-1:0] rdat_q, rdat_d;
  logic [1:0]         sel_q, sel_d;
  logic [2:0]         xss_q, xss_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sclk_q, sclk_d;
  logic               copi_q, copi_d;
  logic [2:0]         sync1_q, sync2_q;

  logic               accept;
  logic               tick;
  logic               cipo_bit;
  logic [C_DAT_W-1:0] tx_sh;

  spi_half_tick #(
    .C_H (C_H)
  ) u_half_tick (
    .CK_i   (CK_i),
    .RST_i  (RST_i),
    .CLR_i  (accept),
    .TICK_o (tick)
  );

  // CIPO lines are asynchronous; each gets its own two-flop synchronizer.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {CIPO_2_i, CIPO_1_i, CIPO_0_i};
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    cipo_bit = 1'b0;
    case (sel_q)
      2'd0:    cipo_bit = sync2_q[0];
      2'd1:    cipo_bit = sync2_q[1];
      2'd2:    cipo_bit = sync2_q[2];
      default: cipo_bit = 1'b0;
    endcase
  end

  assign tx_sh = tx_q << 1;

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdat_d  = rdat_q;
    sel_d   = sel_q;
    xss_d   = xss_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    accept  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (REQ_i && !busy_q) begin
          accept  = 1'b1;
          tx_d    = WDATs_i;
          sel_d   = CS_SELs_i;
          rx_d    = '0;
          hp_d    = '0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          copi_d  = WDATs_i[C_DAT_W-1];
          xss_d   = xss_mask(CS_SELs_i);
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = ST_XFER;
        end
      end

      ST_XFER: begin
        if (tick) begin
          hp_d = hp_q + 1'b1;
          // Even half-periods are high: their last cycle is the sample point.
          if (!hp_q[0]) begin
            rx_d   = C_DAT_W'({rx_q, cipo_bit});
            tx_d   = tx_sh;
            copi_d = tx_sh[C_DAT_W-1];
            sclk_d = 1'b0;
          end else if (hp_q == C_HP_LAST) begin
            sclk_d  = 1'b0;
            state_d = ST_HOLD;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          xss_d   = 3'b111;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (tick) begin
          rdat_d  = rx_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        xss_d   = 3'b111;
      end
    endcase
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state_q <= ST_IDLE;
      hp_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdat_q  <= '0;
      sel_q   <= '0;
      xss_q   <= 3'b111;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdat_q  <= rdat_d;
      sel_q   <= sel_d;
      xss_q   <= xss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
    end
  end

  assign BUSY_o  = busy_q;
  assign DONE_o  = done_q;
  assign RDATs_o = rdat_q;
  assign SCLK_o  = sclk_q;
  assign COPI_o  = copi_q;
  assign XSS_0_o = xss_q[0];
  assign XSS_1_o = xss_q[1];
  assign XSS_2_o = xss_q[2];

endmodule

// File: tb/tb_spi_mst3cs.sv
// Self-checking bench for spi_mst3cs: loopback, a mode-0 slave model, no-select,
// back-to-back, ignored requests and mid-transfer reset, against a byte-level model.
module tb_spi_mst3cs;

  localparam int unsigned F_CK   = 135_000_000;
  localparam int unsigned F_SCLK = 1_000_000;
  localparam int H = (F_CK + 2 * F_SCLK - 1) / (2 * F_SCLK);

  logic       CK_i = 1'b0;
  logic       RST_i = 1'b1;
  logic       REQ_i = 1'b0;
  logic [1:0] CS_SELs_i = 2'd0;
  logic [7:0] WDATs_i = 8'h00;
  logic       BUSY_o, DONE_o, SCLK_o, COPI_o;
  logic [7:0] RDATs_o;
  logic       XSS_0_o, XSS_1_o, XSS_2_o;
  logic       CIPO_0_i, CIPO_1_i, CIPO_2_i;

  logic [2:0] lb_mask = 3'b000;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] s_sh = 8'h00;

  int total = 0;
  int bad = 0;

  assign CIPO_0_i = lb_mask[0] & COPI_o;
  assign CIPO_1_i = lb_mask[1] & COPI_o;
  assign CIPO_2_i = lb_mask[2] ? COPI_o : s_sh[7];

  spi_mst3cs #(
    .C_F_CK   (F_CK),
    .C_F_SCLK (F_SCLK),
    .C_DAT_W  (8)
  ) dut (
    .CK_i      (CK_i),
    .RST_i     (RST_i),
    .REQ_i     (REQ_i),
    .CS_SELs_i (CS_SELs_i),
    .WDATs_i   (WDATs_i),
    .BUSY_o    (BUSY_o),
    .DONE_o    (DONE_o),
    .RDATs_o   (RDATs_o),
    .SCLK_o    (SCLK_o),
    .COPI_o    (COPI_o),
    .XSS_0_o   (XSS_0_o),
    .XSS_1_o   (XSS_1_o),
    .XSS_2_o   (XSS_2_o),
    .CIPO_0_i  (CIPO_0_i),
    .CIPO_1_i  (CIPO_1_i),
    .CIPO_2_i  (CIPO_2_i)
  );

  always #5 CK_i = ~CK_i;

  // Monitor: samples 1 ns after each rising edge; the only writer of these counters.
  int   cyc = 0;
  logic busy_prev = 1'b0, sclk_prev = 1'b0, x0_prev = 1'b1;
  int   busy_rise_cnt = 0, busy_rise_cyc = 0;
  int   done_cnt = 0, done_cyc = 0;
  int   rise_cnt = 0, last_rise_cyc = -1, first_rise_cyc = 0, per_bad = 0;
  int   copi_hi = 0;
  int   xss_low_cnt [3] = '{0, 0, 0};
  int   x0_rise_cyc = 0, x0_gap = 0;
  bit   x0_rise_valid = 1'b0, first_pending = 1'b0;

  always @(posedge CK_i) begin
    #1;
    cyc++;
    if (BUSY_o === 1'b1 && busy_prev !== 1'b1) begin
      busy_rise_cnt++;
      busy_rise_cyc = cyc;
      first_pending = 1'b1;
      last_rise_cyc = -1;
    end
    if (DONE_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (SCLK_o === 1'b1 && sclk_prev !== 1'b1) begin
      rise_cnt++;
      if (first_pending) begin
        first_rise_cyc = cyc;
        first_pending = 1'b0;
      end
      if (last_rise_cyc >= 0 && (cyc - last_rise_cyc) != 2 * H) per_bad++;
      last_rise_cyc = cyc;
    end
    if (BUSY_o === 1'b1 && COPI_o === 1'b1 && (cyc - busy_rise_cyc) < 16 * H) copi_hi++;
    if (XSS_0_o === 1'b0) xss_low_cnt[0]++;
    if (XSS_1_o === 1'b0) xss_low_cnt[1]++;
    if (XSS_2_o === 1'b0) xss_low_cnt[2]++;
    if (x0_prev === 1'b1 && XSS_0_o === 1'b0 && x0_rise_valid) x0_gap = cyc - x0_rise_cyc;
    if (x0_prev === 1'b0 && XSS_0_o === 1'b1) begin
      x0_rise_cyc = cyc;
      x0_rise_valid = 1'b1;
    end
    // Mode-0 slave on CIPO_2: MSB ready at select, next bit after each SCLK fall.
    if (XSS_2_o !== 1'b0) s_sh = slave_byte;
    else if (sclk_prev === 1'b1 && SCLK_o === 1'b0) s_sh = {s_sh[6:0], 1'b0};
    busy_prev = BUSY_o;
    sclk_prev = SCLK_o;
    x0_prev   = XSS_0_o;
  end

  function automatic logic [7:0] ref_rdat(input logic [1:0] sel, input logic [7:0] wdat,
                                          input logic [2:0] lb, input logic [7:0] sb);
    if (sel == 2'd3) return 8'h00;
    if (lb[sel]) return wdat;
    if (sel == 2'd2) return sb;
    return 8'h00;
  endfunction

  task automatic start_req(input logic [1:0] sel, input logic [7:0] wdat);
    @(negedge CK_i);
    REQ_i = 1'b1;
    CS_SELs_i = sel;
    WDATs_i = wdat;
    @(negedge CK_i);
    REQ_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CK_i);
      if (DONE_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CK_i);
    total++; if (BUSY_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", BUSY_o); end
    total++; if (DONE_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", DONE_o); end
    total++; if (RDATs_o !== 8'h00) begin bad++; $display("FAIL rst_rdat got=%h want=00", RDATs_o); end
    total++; if (SCLK_o !== 1'b0) begin bad++; $display("FAIL rst_sclk got=%b want=0", SCLK_o); end
    total++; if (COPI_o !== 1'b0) begin bad++; $display("FAIL rst_copi got=%b want=0", COPI_o); end
    total++;
    if ({XSS_2_o, XSS_1_o, XSS_0_o} !== 3'b111) begin
      bad++; $display("FAIL rst_xss got=%b want=111", {XSS_2_o, XSS_1_o, XSS_0_o});
    end
    RST_i = 1'b0;
    repeat (5) @(negedge CK_i);
    total++; if (BUSY_o !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", BUSY_o); end
  endtask

  task automatic test_xfer(input string name, input logic [1:0] sel, input logic [7:0] wdat);
    int r0, pb0, ch0, d0;
    int xl0 [3];
    int exp_low;
    bit ok;
    logic [7:0] exp_rd;
    r0 = rise_cnt; pb0 = per_bad; ch0 = copi_hi; d0 = done_cnt;
    for (int i = 0; i < 3; i++) xl0[i] = xss_low_cnt[i];
    exp_rd = ref_rdat(sel, wdat, lb_mask, slave_byte);
    start_req(sel, wdat);
    wait_done(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL %s_timeout got=no DONE_o want=DONE_o within 2000 cycles", name);
      return;
    end
    total++; if (RDATs_o !== exp_rd) begin bad++; $display("FAIL %s_rdat got=%h want=%h", name, RDATs_o, exp_rd); end
    total++;
    if (done_cyc - busy_rise_cyc != 19 * H) begin
      bad++; $display("FAIL %s_latency got=%0d want=%0d", name, done_cyc - busy_rise_cyc, 19 * H);
    end
    total++;
    if (first_rise_cyc - busy_rise_cyc != H) begin
      bad++; $display("FAIL %s_first_rise got=%0d want=%0d", name, first_rise_cyc - busy_rise_cyc, H);
    end
    total++; if (rise_cnt - r0 != 8) begin bad++; $display("FAIL %s_rises got=%0d want=8", name, rise_cnt - r0); end
    total++; if (per_bad != pb0) begin bad++; $display("FAIL %s_period got=%0d bad periods want=0", name, per_bad - pb0); end
    total++;
    if (copi_hi - ch0 != 2 * H * $countones(wdat)) begin
      bad++; $display("FAIL %s_copi got=%0d high cycles want=%0d", name, copi_hi - ch0, 2 * H * $countones(wdat));
    end
    for (int i = 0; i < 3; i++) begin
      exp_low = (int'(sel) == i) ? 18 * H : 0;
      total++;
      if (xss_low_cnt[i] - xl0[i] != exp_low) begin
        bad++; $display("FAIL %s_xss%0d got=%0d low cycles want=%0d", name, i, xss_low_cnt[i] - xl0[i], exp_low);
      end
    end
    @(negedge CK_i);
    total++; if (DONE_o !== 1'b0) begin bad++; $display("FAIL %s_done_width got=%b want=0", name, DONE_o); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL %s_done_count got=%0d want=1", name, done_cnt - d0); end
  endtask

  task automatic test_random();
    logic [1:0] sel;
    logic [7:0] wdat;
    for (int n = 0; n < 6; n++) begin
      sel = 2'($urandom_range(0, 3));
      wdat = 8'($urandom);
      lb_mask = 3'($urandom);
      slave_byte = 8'($urandom);
      test_xfer("random", sel, wdat);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d1;
    lb_mask = 3'b001;
    @(negedge CK_i);
    REQ_i = 1'b1; CS_SELs_i = 2'd0; WDATs_i = 8'h01;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CK_i);
      if (BUSY_o === 1'b1) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL b2b_start got=BUSY_o low want=BUSY_o high"); end
    WDATs_i = 8'h80;
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_done1 got=no DONE_o want=DONE_o"); end
    total++; if (RDATs_o !== 8'h01) begin bad++; $display("FAIL b2b_rdat1 got=%h want=01", RDATs_o); end
    d1 = done_cyc;
    @(negedge CK_i);
    REQ_i = 1'b0;
    total++; if (BUSY_o !== 1'b1) begin bad++; $display("FAIL b2b_busy2 got=%b want=1", BUSY_o); end
    total++;
    if (busy_rise_cyc != d1 + 1) begin
      bad++; $display("FAIL b2b_gapless got=%0d want=%0d", busy_rise_cyc - d1, 1);
    end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_done2 got=no DONE_o want=DONE_o"); end
    total++; if (RDATs_o !== 8'h80) begin bad++; $display("FAIL b2b_rdat2 got=%h want=80", RDATs_o); end
    total++; if (x0_gap < H) begin bad++; $display("FAIL b2b_xss_gap got=%0d want>=%0d", x0_gap, H); end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] wa;
    int d0, b0;
    bit ok;
    lb_mask = 3'b010;
    wa = 8'($urandom_range(1, 255));
    d0 = done_cnt; b0 = busy_rise_cnt;
    start_req(2'd1, wa);
    repeat (500) @(negedge CK_i);
    REQ_i = 1'b1; CS_SELs_i = 2'd2; WDATs_i = ~wa;
    @(negedge CK_i);
    REQ_i = 1'b0;
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL ign_done got=no DONE_o want=DONE_o"); end
    total++; if (RDATs_o !== wa) begin bad++; $display("FAIL ign_rdat got=%h want=%h", RDATs_o, wa); end
    repeat (3 * H) @(negedge CK_i);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", done_cnt - d0); end
    total++; if (busy_rise_cnt - b0 != 1) begin bad++; $display("FAIL ign_busy_count got=%0d want=1", busy_rise_cnt - b0); end
    total++; if (BUSY_o !== 1'b0) begin bad++; $display("FAIL ign_idle got=%b want=0", BUSY_o); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    int d0, r0;
    bit ok;
    lb_mask = 3'b010;
    w = 8'($urandom_range(1, 255));
    d0 = done_cnt; r0 = rise_cnt;
    start_req(2'd1, w);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CK_i);
      if (rise_cnt - r0 >= 5) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL rmid_bit4 got=%0d rises want=5", rise_cnt - r0); end
    repeat (H / 2) @(negedge CK_i);
    RST_i = 1'b1;
    @(negedge CK_i);
    RST_i = 1'b0;
    total++; if (BUSY_o !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", BUSY_o); end
    total++; if (SCLK_o !== 1'b0) begin bad++; $display("FAIL rmid_sclk got=%b want=0", SCLK_o); end
    total++;
    if ({XSS_2_o, XSS_1_o, XSS_0_o} !== 3'b111) begin
      bad++; $display("FAIL rmid_xss got=%b want=111", {XSS_2_o, XSS_1_o, XSS_0_o});
    end
    total++; if (RDATs_o !== 8'h00) begin bad++; $display("FAIL rmid_rdat got=%h want=00", RDATs_o); end
    repeat (20 * H) @(negedge CK_i);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL rmid_no_done got=%0d pulses want=0", done_cnt - d0); end
    test_xfer("post_reset", 2'd1, 8'($urandom));
  endtask

  initial begin
    test_reset();
    lb_mask = 3'b010;
    test_xfer("loopback", 2'd1, 8'hA5);
    lb_mask = 3'b000;
    slave_byte = 8'h3C;
    test_xfer("slave2", 2'd2, 8'h00);
    lb_mask = 3'b111;
    slave_byte = 8'hFF;
    test_xfer("nosel", 2'd3, 8'hFF);
    test_random();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=still running want=finished before 200000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
